// File: rtl/pong_ball_engine.sv
// Pong ball engine: ball position/velocity, serve/play/score FSM, once-per-frame
// wall/paddle/goal resolution and a registered ball-pixel overlay.
module pong_ball_engine #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int BALL_SIZE    = 8,
   parameter int PAD_W        = 10,
   parameter int PAD_H        = 90,
   parameter int PAD1_X       = 10,
   parameter int PAD2_X       = 620,
   parameter int SPEED_X      = 2,
   parameter int MAX_DY       = 3,
   parameter int MOVE_DIV     = 1,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk_in,
   input  logic       i_rst,
   input  logic       o_active,
   input  logic [9:0] o_x,
   input  logic [8:0] o_y,
   input  logic [8:0] pos_yBarra1,
   input  logic [8:0] pos_yBarra2,
   output logic       pointPlayer1,
   output logic       pointPlayer2,
   output logic       color,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y
);
   localparam int CX  = (H_RES - BALL_SIZE) / 2;
   localparam int CY  = (V_RES - BALL_SIZE) / 2;
   localparam int FCW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam logic signed [10:0] SPD   = 11'(SPEED_X);
   localparam logic signed [10:0] X_MAX = 11'(H_RES - BALL_SIZE);
   localparam logic signed [10:0] Y_MAX = 11'(V_RES - BALL_SIZE);
   localparam logic signed [10:0] ZH    = 11'(PAD_H / 3);
   localparam logic signed [10:0] ZH2   = 11'(2 * (PAD_H / 3));
   localparam logic signed [10:0] HALF  = 11'(BALL_SIZE / 2);

   typedef enum logic [1:0] {SERVE, PLAY, SCORE} state_t;

   state_t            state, state_n;
   logic [9:0]        bx_n;
   logic [8:0]        by_n;
   logic              dir, dir_n;        // 1 = moving right
   logic signed [3:0] dy, dy_n, dy_abs, mag;
   logic [FCW-1:0]    fcnt, fcnt_n;
   logic [MCW-1:0]    mcnt, mcnt_n;
   logic [15:0]       lfsr;
   logic              p1_n, p2_n, color_n, frame_tick;
   logic              hit1, hit2, hit;
   logic [10:0]       bl, br, bt, bb, py1, py2;
   logic [8:0]        py;
   logic signed [10:0] nx, ny, zd;

   assign frame_tick = (o_x == 10'(H_RES - 1)) && (o_y == 9'(V_RES - 1));

   // Ball box edges in 11 bits so the +size terms never overflow.
   assign bl  = {1'b0, ball_x};
   assign br  = bl + 11'(BALL_SIZE - 1);
   assign bt  = {2'b0, ball_y};
   assign bb  = bt + 11'(BALL_SIZE - 1);
   assign py1 = {2'b0, pos_yBarra1};
   assign py2 = {2'b0, pos_yBarra2};

   assign hit1 = !dir && (bl <= 11'(PAD1_X + PAD_W - 1)) && (br >= 11'(PAD1_X)) &&
                 (bt <= py1 + 11'(PAD_H - 1)) && (bb >= py1);
   assign hit2 = dir && (bl <= 11'(PAD2_X + PAD_W - 1)) && (br >= 11'(PAD2_X)) &&
                 (bt <= py2 + 11'(PAD_H - 1)) && (bb >= py2);
   assign hit  = hit1 || hit2;

   // Negative zone offsets fall below ZH and so clamp to zone 0.
   assign py     = hit1 ? pos_yBarra1 : pos_yBarra2;
   assign zd     = $signed(bt) + HALF - $signed({2'b0, py});
   assign mag    = 4'(1 + (int'(lfsr[1:0]) % MAX_DY));
   assign dy_abs = dy[3] ? -dy : dy;
   assign nx     = dir ? $signed(bl) + SPD : $signed(bl) - SPD;
   assign ny     = $signed(bt) + $signed({{7{dy[3]}}, dy});

   assign color_n = o_active && ({1'b0, o_x} >= bl) && ({1'b0, o_x} <= br) &&
                    ({2'b0, o_y} >= bt) && ({2'b0, o_y} <= bb);

   always_comb begin
      state_n = state;
      bx_n    = ball_x;
      by_n    = ball_y;
      dir_n   = dir;
      dy_n    = dy;
      fcnt_n  = fcnt;
      mcnt_n  = mcnt;
      p1_n    = 1'b0;
      p2_n    = 1'b0;
      case (state)
         SERVE: begin
            bx_n = 10'(CX);
            by_n = 9'(CY);
            dy_n = '0;
            if (frame_tick) begin
               if (fcnt == FCW'(SERVE_FRAMES - 1)) begin
                  state_n = PLAY;
                  fcnt_n  = '0;
                  mcnt_n  = '0;
               end else begin
                  fcnt_n = fcnt + 1'b1;
               end
            end
         end
         PLAY: begin
            if (frame_tick) begin
               if (mcnt != MCW'(MOVE_DIV - 1)) begin
                  mcnt_n = mcnt + 1'b1;
               end else begin
                  mcnt_n = '0;
                  if (hit) begin
                     dir_n = ~dir;
                     dy_n  = (zd < ZH) ? -mag : (zd < ZH2) ? 4'sd0 : mag;
                  end else if (nx <= 11'sd0) begin
                     state_n = SCORE;
                     p2_n    = 1'b1;
                  end else if (nx >= X_MAX) begin
                     state_n = SCORE;
                     p1_n    = 1'b1;
                  end else begin
                     bx_n = nx[9:0];
                     if (ny < 11'sd0) begin
                        by_n = '0;
                        dy_n = dy_abs;
                     end else if (ny > Y_MAX) begin
                        by_n = Y_MAX[8:0];
                        dy_n = -dy_abs;
                     end else begin
                        by_n = ny[8:0];
                     end
                  end
               end
            end
         end
         SCORE: begin
            // Next serve heads toward the scorer's side: right if player 2 scored.
            bx_n    = 10'(CX);
            by_n    = 9'(CY);
            dy_n    = '0;
            dir_n   = pointPlayer2;
            fcnt_n  = '0;
            mcnt_n  = '0;
            state_n = SERVE;
         end
         default: state_n = SERVE;
      endcase
   end

   always_ff @(posedge clk_in or posedge i_rst) begin
      if (i_rst) begin
         state        <= SERVE;
         ball_x       <= 10'(CX);
         ball_y       <= 9'(CY);
         dir          <= 1'b1;
         dy           <= '0;
         fcnt         <= '0;
         mcnt         <= '0;
         lfsr         <= 16'hACE1;
         pointPlayer1 <= 1'b0;
         pointPlayer2 <= 1'b0;
         color        <= 1'b0;
      end else begin
         state        <= state_n;
         ball_x       <= bx_n;
         ball_y       <= by_n;
         dir          <= dir_n;
         dy           <= dy_n;
         fcnt         <= fcnt_n;
         mcnt         <= mcnt_n;
         lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         pointPlayer1 <= p1_n;
         pointPlayer2 <= p2_n;
         color        <= color_n;
      end
   end
endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: stimulus queues expected outputs per cycle,
// a monitor pops and compares them one step after each rising edge.
module tb_pong_ball_engine;
   logic       clk_in = 1'b0;
   logic       i_rst, o_active;
   logic [9:0] o_x;
   logic [8:0] o_y, pos_yBarra1, pos_yBarra2;
   logic       pointPlayer1, pointPlayer2, color;
   logic [9:0] ball_x;
   logic [8:0] ball_y;

   always #5 clk_in = ~clk_in;

   pong_ball_engine dut (
      .clk_in(clk_in), .i_rst(i_rst), .o_active(o_active), .o_x(o_x), .o_y(o_y),
      .pos_yBarra1(pos_yBarra1), .pos_yBarra2(pos_yBarra2),
      .pointPlayer1(pointPlayer1), .pointPlayer2(pointPlayer2), .color(color),
      .ball_x(ball_x), .ball_y(ball_y)
   );

   typedef struct {
      string name;
      bit cp; int bx; int by;
      bit cq; bit p1; bit p2;
      bit cc; bit col;
   } exp_t;

   exp_t        q[$];
   int          tests = 0, fails = 0;
   logic [15:0] lfsr_m, lfsr_tick;
   int          bxe, bye, dye, m, ny, post;
   bit          wall;

   // Reference for the serve-randomiser sequence, reset alongside the DUT.
   always @(posedge clk_in or posedge i_rst)
      if (i_rst) lfsr_m <= 16'hACE1;
      else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};

   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", n, a, e);
      end
   endtask

   function automatic exp_t none();
      exp_t e;
      e.name = "idle"; e.cp = 0; e.bx = 0; e.by = 0;
      e.cq = 0; e.p1 = 0; e.p2 = 0; e.cc = 0; e.col = 0;
      return e;
   endfunction

   function automatic exp_t tkp(input string n, input int x, input int y, input bit a, input bit b);
      exp_t e = none();
      e.name = n; e.cp = 1; e.bx = x; e.by = y;
      e.cq = 1; e.p1 = a; e.p2 = b; e.cc = 1; e.col = 0;
      return e;
   endfunction

   function automatic exp_t tk(input string n, input int x, input int y);
      return tkp(n, x, y, 1'b0, 1'b0);
   endfunction

   function automatic exp_t ec(input string n, input bit c);
      exp_t e = none();
      e.name = n; e.cc = 1; e.col = c;
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.cp) begin
               chk({e.name, "_x"}, int'(ball_x), e.bx);
               chk({e.name, "_y"}, int'(ball_y), e.by);
            end
            if (e.cq) begin
               chk({e.name, "_p1"}, int'(pointPlayer1), int'(e.p1));
               chk({e.name, "_p2"}, int'(pointPlayer2), int'(e.p2));
            end
            if (e.cc) chk({e.name, "_color"}, int'(color), int'(e.col));
         end
      end
   end

   task automatic drive(input logic [9:0] x, input logic [8:0] y, input logic act, input exp_t e);
      @(negedge clk_in);
      o_x = x; o_y = y; o_active = act;
      if (x == 10'd639 && y == 9'd479) lfsr_tick = lfsr_m;
      q.push_back(e);
   endtask

   task automatic frame2(input exp_t et, input exp_t ei);
      drive(10'd639, 9'd479, 1'b0, et);
      drive(10'd0, 9'd0, 1'b0, ei);
   endtask

   task automatic frame(input exp_t et);
      frame2(et, none());
   endtask

   task automatic serve(input string n, input int first_x);
      repeat (60) frame(tk({n, "_hold"}, 316, 236));
      frame(tk({n, "_first"}, first_x, 236));
      bxe = first_x;
   endtask

   task automatic run_x(input string n, input int steps, input int dx);
      repeat (steps) begin
         bxe += dx;
         frame(tk(n, bxe, 236));
      end
   endtask

   task automatic do_rst(input string n);
      @(negedge clk_in);
      o_x = '0; o_y = '0; o_active = 1'b0;
      i_rst = 1'b1;
      #1;
      chk({n, "_p1"}, int'(pointPlayer1), 0);
      chk({n, "_p2"}, int'(pointPlayer2), 0);
      chk({n, "_color"}, int'(color), 0);
      chk({n, "_x"}, int'(ball_x), 316);
      chk({n, "_y"}, int'(ball_y), 236);
      repeat (2) @(negedge clk_in);
      i_rst = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: stimulus still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      i_rst = 1'b0; o_active = 1'b0; o_x = '0; o_y = '0;
      pos_yBarra1 = 9'd200; pos_yBarra2 = 9'd0;
      #1 i_rst = 1'b1;
      #11;
      chk("rst_x", int'(ball_x), 316);
      chk("rst_y", int'(ball_y), 236);
      chk("rst_p1", int'(pointPlayer1), 0);
      chk("rst_p2", int'(pointPlayer2), 0);
      chk("rst_color", int'(color), 0);
      @(negedge clk_in);
      i_rst = 1'b0;

      // Ball overlay at the centred ball (316..323, 236..243)
      drive(10'd316, 9'd236, 1'b1, ec("col_tl", 1'b1));
      drive(10'd323, 9'd243, 1'b1, ec("col_br", 1'b1));
      drive(10'd324, 9'd236, 1'b1, ec("col_right", 1'b0));
      drive(10'd315, 9'd243, 1'b1, ec("col_left", 1'b0));
      drive(10'd316, 9'd244, 1'b1, ec("col_below", 1'b0));
      drive(10'd320, 9'd240, 1'b0, ec("col_inactive", 1'b0));

      // Serve, move right past a missing right paddle into the right goal
      serve("serve1", 318);
      run_x("play_r", 156, 2);
      frame2(tkp("goal_p1", 630, 236, 1'b1, 1'b0), tkp("recentre_p1", 316, 236, 1'b0, 1'b0));

      // Serve goes left; middle-zone bounce off the left paddle
      serve("serve_left", 314);
      run_x("play_l", 148, -2);
      frame(tk("pad1_mid_hit", 18, 236));
      pos_yBarra2 = 9'd200;
      run_x("ret_r", 298, 2);
      frame(tk("pad2_mid_hit", 614, 236));
      pos_yBarra1 = 9'd235;
      run_x("ret_l", 298, -2);
      frame(tk("pad1_top_hit", 18, 236));
      m = 1 + (int'(lfsr_tick[1:0]) % 3);

      // Top-zone hit sends the ball upward into the top wall
      bxe = 18; bye = 236; dye = -m; wall = 0; post = 0;
      while (post < 5) begin
         bxe += 2;
         ny = bye + dye;
         if (ny < 0) begin
            bye = 0; dye = -dye; wall = 1;
         end else begin
            bye = ny;
         end
         frame(tk((wall && post == 0) ? "wall_clamp" : "wall_run", bxe, bye));
         if (wall) post++;
      end

      do_rst("rst_play");
      pos_yBarra2 = 9'd0;
      serve("serve_rst", 318);
      run_x("play_r2", 156, 2);
      drive(10'd639, 9'd479, 1'b0, tkp("goal_p1_rst", 630, 236, 1'b1, 1'b0));
      do_rst("rst_score");

      // Reset during SCORE must not carry the scorer's serve direction
      serve("serve_after_rst", 318);
      run_x("play_r3", 156, 2);
      frame2(tkp("goal_p1b", 630, 236, 1'b1, 1'b0), tkp("recentre_b", 316, 236, 1'b0, 1'b0));
      pos_yBarra1 = 9'd400;
      serve("serve_left2", 314);
      run_x("play_l2", 156, -2);
      frame2(tkp("goal_p2", 2, 236, 1'b0, 1'b1), tkp("recentre_p2", 316, 236, 1'b0, 1'b0));
      serve("serve_right", 318);

      repeat (3) @(negedge clk_in);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
